// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - Shared RAM geometry and loader state encoding.
package ram_pkg;

    localparam int DATA_SIZE     = 16;
    localparam int WORDS_PER_ROW = 256;
    localparam int ROWS          = 32;
    localparam int FIFO_DEPTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Requests beyond the physical row count are served as a full-RAM job.
    function automatic logic [5:0] clamp_rows(input logic [5:0] req, input int max_rows);
        if (int'(req) > max_rows) begin
            return 6'(max_rows);
        end
        return req;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - Synchronous word FIFO with full/empty flags and a show-ahead head word.
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_stream_loader.sv
// rtl/ram_stream_loader.sv - Streams FIFO-buffered words into a row/word-sequenced RAM, or reads rows back out.
module ram_stream_loader #(
    parameter int DATA_SIZE     = ram_pkg::DATA_SIZE,
    parameter int WORDS_PER_ROW = ram_pkg::WORDS_PER_ROW,
    parameter int ROWS          = ram_pkg::ROWS,
    parameter int FIFO_DEPTH    = ram_pkg::FIFO_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode_write,
    input  logic [5:0]           row_count,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 ram_reset,
    output logic                 ram_write1_read0,
    output logic [DATA_SIZE-1:0] ram_data_in,
    input  logic [DATA_SIZE-1:0] ram_data_out,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           underrun_count,
    output logic [4:0]           row_display,
    output logic [7:0]           word_display
);

    import ram_pkg::state_t;
    import ram_pkg::clamp_rows;
    import ram_pkg::ST_IDLE;
    import ram_pkg::ST_PRIME;
    import ram_pkg::ST_RUN;
    import ram_pkg::ST_FLUSH;
    import ram_pkg::ST_DONE;

    localparam logic [7:0] C_WORD_LAST = 8'(WORDS_PER_ROW - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_alive;
    logic                 r_mode;
    logic [5:0]           r_rows;
    logic [7:0]           r_word_cnt;
    logic [4:0]           r_row_cnt;
    logic [7:0]           r_underrun;
    logic                 r_out_valid;
    logic [DATA_SIZE-1:0] r_out_data;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_SIZE-1:0] w_fifo_data;
    logic                 w_write_run;
    logic                 w_read_run;
    logic                 w_run_last;
    logic [5:0]           w_req_rows;

    assign w_req_rows  = clamp_rows(row_count, ROWS);
    assign w_write_run = (r_state == ST_RUN) && r_mode;
    assign w_read_run  = (r_state == ST_RUN) && !r_mode;
    assign w_run_last  = (r_word_cnt == C_WORD_LAST) && ({1'b0, r_row_cnt} == r_rows - 6'd1);

    // r_alive holds in_ready low until the first clock edge after reset release.
    assign in_ready = r_alive && !w_fifo_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_write_run && !w_fifo_empty;

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign underrun_count = r_underrun;
    assign row_display    = r_row_cnt;
    assign word_display   = r_word_cnt;

    word_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        ram_reset        = r_alive;
        ram_write1_read0 = 1'b0;
        ram_data_in      = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (w_req_rows == 6'd0) ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: begin
                busy             = 1'b1;
                ram_reset        = 1'b0;
                ram_write1_read0 = r_mode;
                w_next_state     = ST_RUN;
            end
            ST_RUN: begin
                busy             = 1'b1;
                ram_write1_read0 = r_mode;
                // Only words already resident at the start of the cycle reach the RAM.
                if (r_mode && !w_fifo_empty) begin
                    ram_data_in = w_fifo_data;
                end
                if (w_run_last) begin
                    w_next_state = r_mode ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy             = 1'b1;
                ram_write1_read0 = r_mode;
                w_next_state     = ST_DONE;
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alive     <= 1'b0;
            r_mode      <= 1'b0;
            r_rows      <= '0;
            r_word_cnt  <= '0;
            r_row_cnt   <= '0;
            r_underrun  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_alive     <= 1'b1;
            r_out_valid <= w_read_run;
            if (w_read_run) begin
                r_out_data <= ram_data_out;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode <= mode_write;
                        r_rows <= w_req_rows;
                    end
                end
                ST_PRIME: begin
                    r_word_cnt <= '0;
                    r_row_cnt  <= '0;
                    r_underrun <= '0;
                end
                ST_RUN: begin
                    if (r_word_cnt == C_WORD_LAST) begin
                        r_word_cnt <= '0;
                        r_row_cnt  <= r_row_cnt + 1'b1;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                    if (r_mode && w_fifo_empty && (r_underrun != 8'hFF)) begin
                        r_underrun <= r_underrun + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
// tb/tb_ram_stream_loader.sv - Randomized scoreboard bench for ram_stream_loader against a job-timeline model.
module tb_ram_stream_loader;

    localparam int FD  = 16;
    localparam int WPR = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode_write = 1'b0;
    logic [5:0]  row_count = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        ram_reset;
    logic        ram_write1_read0;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic [7:0]  underrun_count;
    logic [4:0]  row_display;
    logic [7:0]  word_display;

    int n_checks = 0;
    int n_err    = 0;

    ram_stream_loader dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .mode_write       (mode_write),
        .row_count        (row_count),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .ram_reset        (ram_reset),
        .ram_write1_read0 (ram_write1_read0),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .busy             (busy),
        .done             (done),
        .underrun_count   (underrun_count),
        .row_display      (row_display),
        .word_display     (word_display)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: job intervals by cycle number, FIFO contents as a queue.
    int          cyc = 0;
    bit          m_alive = 1'b0;
    logic [15:0] mq[$];
    logic [16:0] sb[$];
    int          j_t0 = -1;
    int          j_rows = 0;
    int          j_run0 = 0;
    int          j_run_last = 0;
    int          j_done = 0;
    bit          j_mode = 1'b0;
    int          m_under = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or posedge reset) begin
        if (reset) m_alive <= 1'b0;
        else       m_alive <= 1'b1;
    end

    always @(negedge clock) begin : model
        int c;
        bit act, prime, run, flush, dn, exp_rdy;
        if (reset) begin
            mq.delete();
            sb.delete();
            j_t0    = -1;
            m_under = 0;
        end else begin
            c     = cyc;
            act   = (j_t0 >= 0) && (c > j_t0) && (c <= j_done);
            prime = act && (j_rows > 0) && (c == j_t0 + 1);
            run   = act && (j_rows > 0) && (c >= j_run0) && (c <= j_run_last);
            flush = act && (j_rows > 0) && !j_mode && (c == j_run_last + 1);
            dn    = act && (c == j_done);
            exp_rdy = m_alive && (mq.size() < FD);
            chk("in_ready", in_ready, exp_rdy);
            chk("busy", busy, act);
            chk("done", done, dn);
            chk("ram_reset", ram_reset, m_alive && !prime);
            chk("ram_write1_read0", ram_write1_read0, j_mode && (prime || run || flush));
            if (prime) m_under = 0;
            if (run) begin
                chk("word_display", word_display, (c - j_run0) % WPR);
                chk("row_display", row_display, (c - j_run0) / WPR);
                if (j_mode) begin
                    if (mq.size() > 0) begin
                        sb.push_back({1'b1, mq.pop_front()});
                    end else begin
                        sb.push_back({1'b1, 16'h0000});
                        if (m_under < 255) m_under++;
                    end
                end else begin
                    sb.push_back({1'b0, ram_data_out});
                end
            end
            if (dn) chk("underrun_count", underrun_count, m_under);
            if (in_valid && exp_rdy) mq.push_back(in_data);
            if (start && !act) begin
                j_t0       = c;
                j_mode     = mode_write;
                j_rows     = (row_count > 6'd32) ? 32 : int'(row_count);
                j_run0     = c + 2;
                j_run_last = c + 1 + j_rows * WPR;
                j_done     = (j_rows == 0) ? c + 1 : (j_mode ? j_run_last + 1 : j_run_last + 2);
            end
        end
    end

    always @(negedge clock) begin : monitor
        logic [16:0] e;
        bit wbeat;
        #2;
        if (!reset) begin
            wbeat = ram_write1_read0 && ram_reset && busy;
            if (wbeat || out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL beat_unexpected: got beat (write=%0b) expected none (t=%0t)", wbeat, $time);
                end else begin
                    e = sb.pop_front();
                    chk("beat_kind", wbeat, e[16]);
                    chk("beat_data", wbeat ? ram_data_in : out_data, e[15:0]);
                end
            end
            if (done) chk("beats_pending", sb.size(), 0);
        end
    end

    task automatic drive_cycle(input int p_valid, input bit noisy);
        @(posedge clock);
        #1;
        in_valid     = ($urandom_range(99) < p_valid);
        in_data      = 16'($urandom);
        ram_data_out = 16'($urandom);
        start        = noisy && ($urandom_range(29) == 0);
        if (start) begin
            mode_write = 1'($urandom);
            row_count  = 6'($urandom);
        end
    endtask

    task automatic run_job(input bit mode, input logic [5:0] rows, input int p_valid, input bit noisy);
        bit got;
        @(posedge clock);
        #1;
        start        = 1'b1;
        mode_write   = mode;
        row_count    = rows;
        in_valid     = ($urandom_range(99) < p_valid);
        in_data      = 16'($urandom);
        ram_data_out = 16'($urandom);
        got = 1'b0;
        for (int k = 0; k < 9000; k++) begin
            drive_cycle(p_valid, noisy);
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("job_done_seen", got, 1);
        repeat (2) drive_cycle(p_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_ram_write1_read0", ram_write1_read0, 0);
        chk("rst_ram_reset", ram_reset, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("release_in_ready_before_edge", in_ready, 0);
        @(posedge clock);
        #1;
        chk("release_in_ready_after_edge", in_ready, 1);
        chk("release_ram_reset", ram_reset, 1);

        for (int i = 1; i <= 16; i++) begin
            @(posedge clock);
            #1;
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = 16'(i);
        end
        run_job(1'b1, 6'd1, 0, 1'b0);

        run_job(1'b1, 6'd2, 100, 1'b0);
        run_job(1'b0, 6'd1, 0, 1'b0);
        run_job(1'b1, 6'd0, 30, 1'b0);
        run_job(1'b0, 6'd0, 30, 1'b0);
        run_job(1'b0, 6'($urandom_range(63, 33)), 50, 1'b1);

        repeat (20) drive_cycle(100, 1'b0);
        run_job(1'b1, 6'd2, 100, 1'b1);

        for (int j = 0; j < 6; j++) begin
            run_job(1'($urandom_range(1)), 6'($urandom_range(3)), $urandom_range(100), 1'b1);
        end

        @(posedge clock);
        #1;
        start      = 1'b1;
        mode_write = 1'b1;
        row_count  = 6'd2;
        in_valid   = 1'b1;
        in_data    = 16'($urandom);
        for (int k = 0; k < 102; k++) drive_cycle(60, 1'b0);
        chk("abort_word", word_display, 100);
        chk("abort_row", row_display, 0);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_ram_reset", ram_reset, 0);
        chk("abort_ram_write1_read0", ram_write1_read0, 0);
        chk("abort_ram_data_in", ram_data_in, 0);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        chk("abort_release_in_ready_before_edge", in_ready, 0);
        @(posedge clock);
        #1;
        chk("abort_release_in_ready_after_edge", in_ready, 1);
        chk("abort_release_ram_reset", ram_reset, 1);
        run_job(1'b1, 6'd1, 0, 1'b0);

        repeat (3) drive_cycle(0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
